// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus an iterative multiply/divide unit with HI/LO registers.
// MD ops take WIDTH+1 cycles after accept; dependent MD instructions stall until IDLE.
module alu_ctrl_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [5:0]       campoFuncion,
    input  logic [1:0]       ALUOp,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       controlDeALU,
    output logic             md_busy,
    output logic             stall,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;     // product high half / partial remainder
    logic [WIDTH-1:0] sreg;    // multiplier bits / dividend bits shifting into quotient
    logic [WIDTH-1:0] opb;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] rs_raw;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    // ---------------- ALU control decode ----------------
    always_comb begin
        controlDeALU = 4'b0010;
        case (ALUOp)
            2'b00: controlDeALU = 4'b0010;
            2'b01: controlDeALU = 4'b0110;
            2'b11: controlDeALU = 4'b0001;
            default: begin
                case (campoFuncion)
                    6'b100000, 6'b100001: controlDeALU = 4'b0010;
                    6'b100010, 6'b100011: controlDeALU = 4'b0110;
                    6'b100100:            controlDeALU = 4'b0000;
                    6'b100101:            controlDeALU = 4'b0001;
                    6'b100110:            controlDeALU = 4'b0011;
                    6'b100111:            controlDeALU = 4'b1100;
                    6'b101010:            controlDeALU = 4'b0111;
                    6'b101011:            controlDeALU = 4'b1000;
                    default:              controlDeALU = 4'b0010;
                endcase
            end
        endcase
    end

    // ---------------- MD instruction classification ----------------
    logic rtype, is_mul_fn, is_div_fn, is_md_fn, idle;
    logic accept_mul, accept_div, do_mthi, do_mtlo;

    assign rtype     = (ALUOp == 2'b10);
    assign is_mul_fn = rtype && (campoFuncion == F_MULT || campoFuncion == F_MULTU);
    assign is_div_fn = rtype && (campoFuncion == F_DIV  || campoFuncion == F_DIVU);
    assign is_md_fn  = is_mul_fn || is_div_fn ||
                       (rtype && (campoFuncion == F_MFHI || campoFuncion == F_MTHI ||
                                  campoFuncion == F_MFLO || campoFuncion == F_MTLO));
    assign idle       = (state_q == IDLE);
    assign accept_mul = in_valid && idle && is_mul_fn;
    assign accept_div = in_valid && idle && is_div_fn;
    assign do_mthi    = in_valid && idle && rtype && (campoFuncion == F_MTHI);
    assign do_mtlo    = in_valid && idle && rtype && (campoFuncion == F_MTLO);

    assign md_busy = !idle;
    assign stall   = in_valid && md_busy && is_md_fn;

    always_comb begin
        mf_data = '0;
        if (in_valid && rtype && campoFuncion == F_MFHI)
            mf_data = hi;
        else if (in_valid && rtype && campoFuncion == F_MFLO)
            mf_data = lo;
    end

    // ---------------- operand conditioning ----------------
    logic             sgn, rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    assign sgn    = !campoFuncion[0];   // mult/div are even encodings, unsigned forms odd
    assign rs_neg = sgn && rs_val[WIDTH-1];
    assign rt_neg = sgn && rt_val[WIDTH-1];
    assign rs_mag = rs_neg ? (~rs_val + 1'b1) : rs_val;
    assign rt_mag = rt_neg ? (~rt_val + 1'b1) : rt_val;

    // ---------------- iteration datapath ----------------
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    assign msum  = {1'b0, acc} + (sreg[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign trial = {acc, sreg[WIDTH-1]};
    assign ge    = (trial >= {1'b0, opb});
    // Remainder stays below the divisor, so the difference always fits WIDTH bits when ge.
    assign diff  = trial[WIDTH-1:0] - opb;

    assign prod   = {acc, sreg};
    assign prod_s = neg_q ? (~prod + 1'b1) : prod;
    assign quo_s  = neg_q ? (~sreg + 1'b1) : sreg;
    assign rem_s  = neg_r ? (~acc + 1'b1) : acc;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_mul)
                    state_d = MUL;
                else if (accept_div)
                    state_d = DIV;
            end
            MUL:  if (cnt == LAST) state_d = DONE;
            DIV:  if (cnt == LAST) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            sreg   <= '0;
            opb    <= '0;
            rs_raw <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt <= '0;
                    if (accept_mul || accept_div) begin
                        acc    <= '0;
                        rs_raw <= rs_val;
                        is_div <= accept_div;
                        neg_q  <= rs_neg ^ rt_neg;
                        neg_r  <= rs_neg;
                        dz     <= (rt_val == '0);
                        sreg   <= accept_div ? rs_mag : rt_mag;
                        opb    <= accept_div ? rt_mag : rs_mag;
                    end else begin
                        if (do_mthi) hi <= rs_val;
                        if (do_mtlo) lo <= rs_val;
                    end
                end
                MUL: begin
                    cnt  <= cnt + 1'b1;
                    acc  <= msum[WIDTH:1];
                    sreg <= {msum[0], sreg[WIDTH-1:1]};
                end
                DIV: begin
                    cnt  <= cnt + 1'b1;
                    acc  <= ge ? diff : trial[WIDTH-1:0];
                    sreg <= {sreg[WIDTH-2:0], ge};
                end
                DONE: begin
                    cnt <= '0;
                    if (!is_div) begin
                        hi <= prod_s[2*WIDTH-1:WIDTH];
                        lo <= prod_s[WIDTH-1:0];
                    end else if (dz) begin
                        hi <= rs_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_s;
                        lo <= quo_s;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv: decode table, mthi/mtlo/mfhi/mflo, mul/div results,
// latency, stall behaviour and mid-operation reset.
module tb_alu_ctrl_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [5:0]  campoFuncion;
    logic [1:0]  ALUOp;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [3:0]  controlDeALU;
    logic        md_busy;
    logic        stall;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    int n;

    alu_ctrl_muldiv #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .campoFuncion (campoFuncion),
        .ALUOp        (ALUOp),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .controlDeALU (controlDeALU),
        .md_busy      (md_busy),
        .stall        (stall),
        .mf_data      (mf_data),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid     = v;
        ALUOp        = op;
        campoFuncion = fn;
        rs_val       = a;
        rt_val       = b;
    endtask

    // Issue an MD op for one cycle, then count busy cycles (bounded).
    task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles);
        drive(1'b1, 2'b10, fn, a, b);
        cyc();
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        busy_cycles = 0;
        while (md_busy && busy_cycles < 200) begin
            busy_cycles++;
            cyc();
        end
    endtask

    initial begin
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        reset = 1'b1;
        cyc();
        cyc();
        chk("rst_busy", {63'd0, md_busy}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        reset = 1'b0;

        // ALU control decode
        drive(1'b0, 2'b10, 6'b101010, 0, 0); #1 chk("dec_slt", {60'd0, controlDeALU}, 64'h7);
        drive(1'b0, 2'b01, 6'b100000, 0, 0); #1 chk("dec_sub", {60'd0, controlDeALU}, 64'h6);
        drive(1'b0, 2'b10, 6'b111111, 0, 0); #1 chk("dec_dflt", {60'd0, controlDeALU}, 64'h2);
        drive(1'b0, 2'b11, 6'b100100, 0, 0); #1 chk("dec_ori", {60'd0, controlDeALU}, 64'h1);
        drive(1'b0, 2'b00, 6'b100010, 0, 0); #1 chk("dec_add", {60'd0, controlDeALU}, 64'h2);
        drive(1'b0, 2'b10, 6'b100111, 0, 0); #1 chk("dec_nor", {60'd0, controlDeALU}, 64'hC);
        drive(1'b0, 2'b10, 6'b101011, 0, 0); #1 chk("dec_sltu", {60'd0, controlDeALU}, 64'h8);
        drive(1'b0, 2'b10, 6'b100100, 0, 0); #1 chk("dec_and", {60'd0, controlDeALU}, 64'h0);
        drive(1'b0, 2'b10, 6'b100110, 0, 0); #1 chk("dec_xor", {60'd0, controlDeALU}, 64'h3);
        drive(1'b0, 2'b10, 6'b100011, 0, 0); #1 chk("dec_subu", {60'd0, controlDeALU}, 64'h6);

        // mthi / mtlo / mfhi / mflo
        drive(1'b1, 2'b10, 6'b010001, 32'h1234_5678, 0);
        cyc();
        chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        chk("mthi_busy", {63'd0, md_busy}, 64'd0);
        drive(1'b1, 2'b10, 6'b010011, 32'hCAFE_BABE, 0);
        cyc();
        chk("mtlo_lo", {32'd0, lo}, 64'hCAFE_BABE);
        chk("mtlo_hi_kept", {32'd0, hi}, 64'h1234_5678);
        drive(1'b1, 2'b10, 6'b010000, 0, 0); #1
        chk("mfhi", {32'd0, mf_data}, 64'h1234_5678);
        chk("mfhi_stall", {63'd0, stall}, 64'd0);
        drive(1'b1, 2'b10, 6'b010010, 0, 0); #1
        chk("mflo", {32'd0, mf_data}, 64'hCAFE_BABE);
        drive(1'b1, 2'b10, 6'b100000, 0, 0); #1
        chk("mf_other", {32'd0, mf_data}, 64'd0);
        drive(1'b0, 2'b00, 6'd0, 0, 0);
        cyc();

        // multu / mult
        run_md(6'b011001, 32'hFFFF_FFFF, 32'h2, n);
        chk("multu_lat", n, 33);
        chk("multu_hi", {32'd0, hi}, 64'h1);
        chk("multu_lo", {32'd0, lo}, 64'hFFFF_FFFE);
        run_md(6'b011000, 32'hFFFF_FFFD, 32'h5, n);
        chk("mult_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult_neg_lo", {32'd0, lo}, 64'hFFFF_FFF1);
        run_md(6'b011000, 32'hFFFF_FFFD, 32'hFFFF_FFFB, n);
        chk("mult_nn_hi", {32'd0, hi}, 64'h0);
        chk("mult_nn_lo", {32'd0, lo}, 64'hF);

        // div / divu including corner cases
        run_md(6'b011010, 32'hFFFF_FFF9, 32'h2, n);
        chk("div_lat", n, 33);
        chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        run_md(6'b011011, 32'h5, 32'h0, n);
        chk("divu0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        chk("divu0_hi", {32'd0, hi}, 64'h5);
        run_md(6'b011010, 32'hFFFF_FFF9, 32'h0, n);
        chk("div0_lat", n, 33);
        chk("div0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        chk("div0_hi", {32'd0, hi}, 64'hFFFF_FFF9);
        run_md(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("divov_lo", {32'd0, lo}, 64'h8000_0000);
        chk("divov_hi", {32'd0, hi}, 64'h0);
        run_md(6'b011011, 32'hFFFF_FFF9, 32'h2, n);
        chk("divu_lo", {32'd0, lo}, 64'h7FFF_FFFC);
        chk("divu_hi", {32'd0, hi}, 64'h1);
        run_md(6'b011010, 32'd100, 32'hFFFF_FFF9, n);
        chk("div_pn_lo", {32'd0, lo}, 64'hFFFF_FFF2);
        chk("div_pn_hi", {32'd0, hi}, 64'h2);

        // mflo one cycle after mult accept stalls until the result lands
        drive(1'b1, 2'b10, 6'b011000, 32'd7, 32'd6);
        cyc();
        drive(1'b0, 2'b00, 6'd0, 0, 0);
        cyc();
        drive(1'b1, 2'b10, 6'b010010, 0, 0);
        #1 n = 0;
        while (stall && n < 200) begin
            n++;
            cyc();
        end
        chk("mflo_stall_len", n, 32);
        chk("mflo_after", {32'd0, mf_data}, 64'd42);
        chk("mflo_busy_after", {63'd0, md_busy}, 64'd0);
        drive(1'b0, 2'b00, 6'd0, 0, 0);

        // mthi arriving while busy waits and then applies
        drive(1'b1, 2'b10, 6'b011001, 32'd3, 32'd4);
        cyc();
        drive(1'b1, 2'b10, 6'b010001, 32'h0000_ABCD, 0);
        #1 n = 0;
        while (stall && n < 200) begin
            n++;
            cyc();
        end
        chk("mthi_wait_len", n, 33);
        cyc();
        drive(1'b0, 2'b00, 6'd0, 0, 0);
        chk("mthi_late_hi", {32'd0, hi}, 64'hABCD);
        chk("mthi_late_lo", {32'd0, lo}, 64'd12);

        // a non-MD instruction during busy never stalls
        drive(1'b1, 2'b10, 6'b011001, 32'd9, 32'd9);
        cyc();
        drive(1'b1, 2'b10, 6'b100000, 0, 0); #1
        chk("nonmd_nostall", {63'd0, stall}, 64'd0);

        // reset in the middle of a multiply aborts it
        drive(1'b0, 2'b00, 6'd0, 0, 0);
        for (int i = 0; i < 8; i++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drive(1'b1, 2'b10, 6'b010010, 0, 0); #1
        chk("abort_busy", {63'd0, md_busy}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        chk("abort_stall", {63'd0, stall}, 64'd0);
        drive(1'b0, 2'b00, 6'd0, 0, 0);
        for (int i = 0; i < 40; i++) cyc();
        chk("abort_lo_late", {32'd0, lo}, 64'd0);
        chk("abort_busy_late", {63'd0, md_busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_muldiv.md
ALU_CTRL_MULDIV -- requirements
Module: alu_ctrl_muldiv

Interface
REQ-001 Parameter: WIDTH, 32, datapath width in bits for operands, HI and LO (legal: 8..64, even).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  instruction present this cycle.
REQ-005 Port: campoFuncion  input  6  R-type function field.
REQ-006 Port: ALUOp  input  2  main-control ALU operation class.
REQ-007 Port: rs_val  input  WIDTH  first operand (dividend/multiplicand; mthi/mtlo source).
REQ-008 Port: rt_val  input  WIDTH  second operand (divisor/multiplier).
REQ-009 Port: controlDeALU  output  4  ALU control code, combinational.
REQ-010 Port: md_busy  output  1  multiply/divide in progress.
REQ-011 Port: stall  output  1  combinational; pipeline hold request.
REQ-012 Port: mf_data  output  WIDTH  HI (mfhi) or LO (mflo), combinational; 0 otherwise.
REQ-013 Port: hi  output  WIDTH  HI register.
REQ-014 Port: lo  output  WIDTH  LO register.

Function
REQ-015 ALUOp 00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 0001 (or); 10 -> decode campoFuncion.
REQ-016 Decode: 100000/100001 -> 0010; 100010/100011 -> 0110; 100100 -> 0000; 100101 -> 0001; 100110 -> 0011; 100111 -> 1100; 101010 -> 0111; 101011 -> 1000; others -> 0010.
REQ-017 MD ops (ALUOp=10 only): 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo.
REQ-018 FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-019 IDLE + in_valid + mult/multu -> MUL; + div/divu -> DIV; operands and signedness latched on that edge (accept edge).
REQ-020 MUL/DIV run iteratively, one bit per cycle, for exactly WIDTH cycles via counter, then DONE.
REQ-021 DONE lasts one cycle; HI/LO written on the DONE->IDLE edge; result visible WIDTH+1 cycles after accept edge.
REQ-022 md_busy = 1 in MUL, DIV, DONE; 0 in IDLE.
REQ-023 stall = in_valid & md_busy & (campoFuncion is any REQ-017 op) & ALUOp=10; non-MD instructions never stall.
REQ-024 MD instruction arriving while md_busy is not accepted; it stays stalled and is accepted at first IDLE cycle.
REQ-025 mult/multu: {HI,LO} = full 2*WIDTH product; signed via magnitude then conditional two's-complement negate.
REQ-026 div/divu: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
REQ-027 Divide by zero (signed or unsigned): LO = all ones, HI = rs_val; normal latency.
REQ-028 Signed overflow (most-negative / -1): LO = most-negative value, HI = 0.
REQ-029 mthi/mtlo in IDLE: HI/LO <= rs_val on that edge; no busy period.
REQ-030 mfhi/mflo in IDLE: mf_data = HI/LO same cycle; while busy, stall per REQ-023.

Reset
REQ-031 reset sampled high: state IDLE, counter 0, HI = LO = 0, md_busy = 0, latched operands cleared, on that edge.
REQ-032 reset mid-operation aborts the operation; no HI/LO update from it.
REQ-033 reset has priority over any accept, mthi/mtlo or DONE write in the same cycle.

Verification
REQ-034 ALUOp=10, funct=101010 -> controlDeALU=0111; ALUOp=01, funct=100000 -> 0110; ALUOp=10, funct=111111 -> 0010.
REQ-035 multu rs=0xFFFFFFFF rt=0x2 -> md_busy high 33 cycles; then HI=0x00000001, LO=0xFFFFFFFE.
REQ-036 div rs=0xFFFFFFF9 (-7) rt=0x2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1) after 33 cycles.
REQ-037 divu rs=0x5 rt=0x0 -> LO=0xFFFFFFFF, HI=0x00000005.
REQ-038 mflo issued 1 cycle after mult accept -> stall=1 for 32 cycles, then stall=0, mf_data = new LO.
REQ-039 reset pulsed in cycle 10 of mult -> next cycle md_busy=0, HI=LO=0, stall=0.
